// File: rtl/clkdiv_pkg.sv
// Purpose : shared constants and the high-time clamp for the multi-channel clock divider.
// Latency : n/a (package only).
// Backpressure: n/a.
package clkdiv_pkg;

    localparam int DEF_W       = 28;   // counter / divisor / high-time width
    localparam int DEF_DIVISOR = 30;   // divisor every channel comes out of reset with
    localparam int MIN_DIV     = 2;    // smallest divisor that still yields a waveform

    // A high time of zero or one that covers the whole period would give a
    // flat output, so those requests fall back to a 50% duty cycle.
    // Operates on 32-bit values; callers zero-extend W-bit fields (W <= 32).
    function automatic logic [31:0] clamp_high(input logic [31:0] div, input logic [31:0] high);
        if (high == 32'd0 || high >= div) begin
            return div >> 1;
        end
        return high;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// Purpose : one divider slice - period counter, active div/high, shadow pdiv/phigh, registered outputs.
// Latency : clk_out/tick are registered, one clk_in cycle after the counter value they reflect.
// Backpressure: none; a shadow load is held (pending) until the period boundary, en=0 or sync.
//
// Ports: clk_in/rst_n clock and async active-low reset; en run enable; sync restart pulse;
//        load/load_div/load_high validated shadow write; clk_out/tick/pending outputs.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEF_DIV = DEF_DIVISOR
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync,
    input  logic         load,
    input  logic [W-1:0] load_div,
    input  logic [W-1:0] load_high,
    output logic         clk_out,
    output logic         tick,
    output logic         pending
);

    localparam logic [W-1:0] RST_DIV  = W'(DEF_DIV);
    localparam logic [W-1:0] RST_HIGH = W'(DEF_DIV >> 1);

    logic [W-1:0] counter;
    logic [W-1:0] div;
    logic [W-1:0] high;
    logic [W-1:0] pdiv;
    logic [W-1:0] phigh;
    logic [W-1:0] load_high_clamped;
    logic         at_end;
    logic         apply;

    assign load_high_clamped = W'(clamp_high(32'(load_div), 32'(load_high)));

    // div is never below 2, so div-1 cannot underflow.
    assign at_end = (counter == div - W'(1));

    // Shadow values move to the active set only where a period would end anyway
    // (or the channel is idle / being restarted), so no period is ever cut short.
    assign apply  = pending && (at_end || !en || sync);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            div     <= RST_DIV;
            high    <= RST_HIGH;
            pdiv    <= RST_DIV;
            phigh   <= RST_HIGH;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (en) begin
                clk_out <= (counter < high);
                tick    <= (counter == '0);
                counter <= (sync || at_end) ? '0 : counter + W'(1);
            end else begin
                clk_out <= 1'b0;
                tick    <= 1'b0;
                counter <= '0;
            end

            if (apply) begin
                div     <= pdiv;
                high    <= phigh;
                counter <= '0;
                pending <= 1'b0;
            end

            // A write landing on the apply edge is kept for the next boundary:
            // the apply above used the old shadow, this overrides pending.
            if (load) begin
                pdiv    <= load_div;
                phigh   <= load_high_clamped;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// Purpose : NCH-channel programmable clock-enable divider; write decode, error flag and sync fan-out.
// Latency : wr_err one cycle after a rejected write; channel outputs registered (see clkdiv_channel).
// Backpressure: none; writes are always taken or rejected in the cycle they are presented.
//
// Ports: clk_in, rst_n; en[NCH] per-channel run; sync global restart; wr_en/wr_ch/wr_div/wr_high
//        config write; wr_err reject pulse; clk_out/tick/pending[NCH] per-channel outputs.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int W       = DEF_W,
    parameter int DEF_DIV = DEF_DIVISOR,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_in,
    input  logic           rst_n,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           wr_en,
    input  logic [CW-1:0]  wr_ch,
    input  logic [W-1:0]   wr_div,
    input  logic [W-1:0]   wr_high,
    output logic           wr_err,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pending
);

    logic wr_ok;

    // Index range matters only when NCH is not a power of two.
    assign wr_ok = (wr_div >= W'(MIN_DIV)) && (int'(wr_ch) < NCH);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic load;
        assign load = wr_en && wr_ok && (wr_ch == CW'(g));

        clkdiv_channel #(
            .W       (W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .en        (en[g]),
            .sync      (sync),
            .load      (load),
            .load_div  (wr_div),
            .load_high (wr_high),
            .clk_out   (clk_out[g]),
            .tick      (tick[g]),
            .pending   (pending[g])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
module tb_clkdiv_multi;
    import clkdiv_pkg::*;

    localparam int NCH = 4;
    localparam int W   = 28;
    localparam int CW  = 2;

    logic           clk_in = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           sync;
    logic           wr_en;
    logic [CW-1:0]  wr_ch;
    logic [W-1:0]   wr_div;
    logic [W-1:0]   wr_high;
    logic           wr_err;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    clkdiv_multi #(.NCH(NCH), .W(W), .DEF_DIV(30)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_high (wr_high),
        .wr_err  (wr_err),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    // ---------------- reference model ----------------
    int unsigned m_cnt[NCH], m_div[NCH], m_high[NCH], m_pdiv[NCH], m_phigh[NCH];
    bit          m_pend[NCH], m_clk[NCH], m_tick[NCH];
    bit          m_err;

    typedef struct packed {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tck;
        logic [NCH-1:0] pnd;
        logic           err;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_div[i] = 30; m_high[i] = 15;
            m_pdiv[i] = 30; m_phigh[i] = 15;
            m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_step();
        bit ok, hit, app;
        int unsigned ncnt;
        ok = wr_en && (wr_div >= W'(2)) && (int'(wr_ch) < NCH);
        for (int i = 0; i < NCH; i++) begin
            hit = (m_cnt[i] == m_div[i] - 1);
            app = m_pend[i] && (hit || !en[i] || sync);
            if (en[i]) begin
                m_clk[i]  = (m_cnt[i] < m_high[i]);
                m_tick[i] = (m_cnt[i] == 0);
                ncnt      = (sync || hit) ? 0 : m_cnt[i] + 1;
            end else begin
                m_clk[i] = 0; m_tick[i] = 0; ncnt = 0;
            end
            if (app) begin
                m_div[i] = m_pdiv[i]; m_high[i] = m_phigh[i]; ncnt = 0; m_pend[i] = 0;
            end
            if (ok && int'(wr_ch) == i) begin
                m_pdiv[i]  = wr_div;
                m_phigh[i] = clamp_high(32'(wr_div), 32'(wr_high));
                m_pend[i]  = 1;
            end
            m_cnt[i] = ncnt;
        end
        m_err = wr_en && !ok;
    endtask

    // One clock: model predicts, expectation queued, DUT sampled 1 time unit after the edge.
    task automatic cycle();
        exp_t e, got;
        model_step();
        for (int i = 0; i < NCH; i++) begin
            e.clk[i] = m_clk[i]; e.tck[i] = m_tick[i]; e.pnd[i] = m_pend[i];
        end
        e.err = m_err;
        sbq.push_back(e);
        @(posedge clk_in);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sbq.pop_front();
            chk("sb", 32'({clk_out, tick, pending, wr_err}), 32'(got));
        end
    endtask

    // ---------------- table of configuration writes ----------------
    typedef struct {
        int ch;
        int div;
        int high;
        bit exp_err;
        int meas;     // cycles measured after enabling
        int exp_hi;   // clk_out high cycles expected in that window
    } vec_t;
    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi[NCH];
        int tk[NCH];
        int n;
        logic [7:0] pat_c, pat_t;
        logic [5:0] pat6_c, pat6_t;

        vecs[0] = '{2, 10,  0, 1'b0, 10, 5};
        vecs[1] = '{2,  1,  1, 1'b1, 10, 5};
        vecs[2] = '{3, 10, 10, 1'b0, 10, 5};
        vecs[3] = '{3,  7,  3, 1'b0,  7, 3};
        vecs[4] = '{0,  5,  4, 1'b0,  5, 4};
        vecs[5] = '{0,  0,  3, 1'b1,  5, 4};
        vecs[6] = '{1, 13, 20, 1'b0, 13, 6};
        vecs[7] = '{3,  3,  0, 1'b0,  3, 1};
        vecs[8] = '{1,  2,  1, 1'b0,  2, 1};

        rst_n = 1'b0; en = '0; sync = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_high = '0;
        model_reset();
        #2;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick",    32'(tick),    32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_wr_err",  32'(wr_err),  32'd0);
        @(posedge clk_in); #1;
        rst_n = 1'b1;

        // Default divisor: 15 high / 15 low, one tick per 30 cycles, all in phase.
        en = '1;
        for (int i = 0; i < NCH; i++) begin hi[i] = 0; tk[i] = 0; end
        for (int c = 0; c < 60; c++) begin
            cycle();
            for (int i = 0; i < NCH; i++) begin
                if (c < 30) hi[i] += int'(clk_out[i]);
                tk[i] += int'(tick[i]);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            chk("def_high", 32'(hi[i]), 32'd15);
            chk("def_ticks", 32'(tk[i]), 32'd2);
        end

        // ch1 div=2 written at counter 10: pending until the boundary, then clk_in/2.
        n = 0;
        while (m_cnt[1] != 10 && n < 100) begin cycle(); n++; end
        chk("align_cnt10", 32'(m_cnt[1]), 32'd10);
        wr_en = 1'b1; wr_ch = CW'(1); wr_div = W'(2); wr_high = W'(1);
        cycle();
        wr_en = 1'b0;
        n = 0;
        while (pending[1] && n < 100) begin n++; cycle(); end
        chk("ch1_pend_cycles", 32'(n), 32'd19);
        chk("ch1_apply_clk", 32'(clk_out[1]), 32'd0);
        for (int c = 0; c < 6; c++) begin
            cycle();
            pat6_c[5-c] = clk_out[1];
            pat6_t[5-c] = tick[1];
        end
        chk("ch1_toggle", 32'(pat6_c), 32'b101010);
        chk("ch1_tick2", 32'(pat6_t), 32'b101010);

        // Table-driven writes, each applied to an idle channel and then measured.
        for (int k = 0; k < 9; k++) begin
            int c;
            c = vecs[k].ch;
            en[c] = 1'b0;
            cycle();
            wr_en = 1'b1; wr_ch = CW'(c); wr_div = W'(vecs[k].div); wr_high = W'(vecs[k].high);
            cycle();
            wr_en = 1'b0;
            chk("tbl_err", 32'(wr_err), 32'(vecs[k].exp_err));
            chk("tbl_pend", 32'(pending[c]), 32'(!vecs[k].exp_err));
            cycle();
            chk("tbl_err_clr", 32'(wr_err), 32'd0);
            chk("tbl_pend_clr", 32'(pending[c]), 32'd0);
            en[c] = 1'b1;
            hi[0] = 0; tk[0] = 0;
            for (int j = 0; j < vecs[k].meas; j++) begin
                cycle();
                hi[0] += int'(clk_out[c]);
                tk[0] += int'(tick[c]);
            end
            chk("tbl_high", 32'(hi[0]), 32'(vecs[k].exp_hi));
            chk("tbl_ticks", 32'(tk[0]), 32'd1);
        end

        // Channels at different phases, then sync (carrying a write to an already pending ch2).
        en = '0;
        cycle();
        en[0] = 1'b1; repeat (3) cycle();
        en[1] = 1'b1; repeat (2) cycle();
        en[2] = 1'b1; cycle();
        en[3] = 1'b1; repeat (4) cycle();
        wr_en = 1'b1; wr_ch = CW'(2); wr_div = W'(6); wr_high = W'(3);
        cycle();
        wr_div = W'(4); wr_high = W'(0); sync = 1'b1;
        cycle();
        wr_en = 1'b0; sync = 1'b0;
        chk("sync_pend_new", 32'(pending[2]), 32'd1);
        cycle();
        chk("sync_clk_all", 32'(clk_out), 32'hF);
        chk("sync_tick_all", 32'(tick), 32'hF);
        hi[0] = 0;
        for (int j = 0; j < 5; j++) begin cycle(); hi[0] += int'(clk_out[2]); end
        chk("sync_old_shadow_hi", 32'(hi[0]), 32'd2);
        chk("sync_pend_done", 32'(pending[2]), 32'd0);

        // ch0 div=8 while disabled: applied at once, then 4 high / 4 low from enable.
        en[0] = 1'b0;
        wr_en = 1'b1; wr_ch = CW'(0); wr_div = W'(8); wr_high = W'(4);
        cycle();
        wr_en = 1'b0;
        chk("idle_pend_set", 32'(pending[0]), 32'd1);
        cycle();
        chk("idle_pend_clr", 32'(pending[0]), 32'd0);
        en[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            pat_c[7-c] = clk_out[0];
            pat_t[7-c] = tick[0];
        end
        chk("ch0_wave", 32'(pat_c), 32'b11110000);
        chk("ch0_tick", 32'(pat_t), 32'b10000000);

        // Async reset mid-period with a load pending.
        wr_en = 1'b1; wr_ch = CW'(3); wr_div = W'(20); wr_high = W'(7);
        cycle();
        wr_en = 1'b0;
        chk("pre_rst_pend", 32'(pending[3]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_clk_out", 32'(clk_out), 32'd0);
        chk("arst_tick",    32'(tick),    32'd0);
        chk("arst_pending", 32'(pending), 32'd0);
        chk("arst_wr_err",  32'(wr_err),  32'd0);
        model_reset();
        sbq.delete();
        repeat (2) @(posedge clk_in);
        #1;
        chk("arst_hold_clk", 32'(clk_out), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) begin hi[i] = 0; tk[i] = 0; end
        for (int c = 0; c < 30; c++) begin
            cycle();
            for (int i = 0; i < NCH; i++) begin
                hi[i] += int'(clk_out[i]);
                tk[i] += int'(tick[i]);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            chk("post_rst_high", 32'(hi[i]), 32'd15);
            chk("post_rst_ticks", 32'(tk[i]), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
